keypad_event: RTL

KEYPAD_EVENT -- requirements
Module: keypad_event

---
 rtl/keypad_event_pkg.sv | 47 ++++
 rtl/keypad_event_tick_gen.sv | 29 ++
 rtl/keypad_event.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/keypad_event_pkg.sv
// rtl/keypad_event_pkg.sv - shared keypad FSM states, column drives and key codes
package keypad_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_ACCEPT,
        ST_HOLD,
        ST_RELEASE
    } kp_state_e;

    localparam logic [2:0] COL_NONE = 3'b000;
    localparam logic [2:0] COL_1    = 3'b001;
    localparam logic [2:0] COL_2    = 3'b010;
    localparam logic [2:0] COL_3    = 3'b100;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    function automatic logic [2:0] next_col(input logic [2:0] col);
        logic [2:0] nc;
        case (col)
            COL_1:   nc = COL_2;
            COL_2:   nc = COL_3;
            default: nc = COL_1;
        endcase
        return nc;
    endfunction

    // Row 4 is the odd one out: *, 0, # instead of a digit run.
    function automatic logic [3:0] key_decode(input logic [2:0] col, input logic [3:0] row);
        logic [3:0] code;
        logic [1:0] c;
        c = (col == COL_3) ? 2'd2 : (col == COL_2) ? 2'd1 : 2'd0;
        case (row)
            4'b0001: code = 4'd1 + {2'b00, c};
            4'b0010: code = 4'd4 + {2'b00, c};
            4'b0100: code = 4'd7 + {2'b00, c};
            4'b1000: code = (c == 2'd0) ? KEY_STAR : (c == 2'd1) ? KEY_0 : KEY_HASH;
            default: code = KEY_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_event_tick_gen.sv
// rtl/keypad_event_tick_gen.sv - single-cycle scan enable every TICK_DIV+1 clocks
module tick_gen #(
    parameter int TICK_DIV = 24999
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/keypad_event.sv
// rtl/keypad_event.sv - 3x4 keypad scanner with press/release debounce and one pulse per key
module keypad_event
    import keypad_event_pkg::*;
#(
    parameter int TICK_DIV  = 24999,
    parameter int DEB_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int CW = $clog2(DEB_TICKS) + 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    kp_state_e     r_state, w_state_nx;
    logic [2:0]    r_col, w_col_nx;
    logic [3:0]    r_row_snap, w_row_snap_nx;
    logic [CW-1:0] r_deb_cnt, w_deb_cnt_nx;
    logic [3:0]    r_code, w_code_nx;
    logic          r_held, w_held_nx;

    logic          w_tick;
    logic          w_row_idle;
    logic          w_snap_onehot;
    logic [CW-1:0] w_deb_inc;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_row_idle    = (key_row == 4'b0000);
    assign w_snap_onehot = (r_row_snap != 4'b0000) && ((r_row_snap & (r_row_snap - 4'd1)) == 4'b0000);
    assign w_deb_inc     = (r_deb_cnt == CNT_MAX) ? r_deb_cnt : r_deb_cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_col      <= COL_NONE;
            r_row_snap <= 4'b0000;
            r_deb_cnt  <= '0;
            r_code     <= KEY_0;
            r_held     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_col      <= w_col_nx;
            r_row_snap <= w_row_snap_nx;
            r_deb_cnt  <= w_deb_cnt_nx;
            r_code     <= w_code_nx;
            r_held     <= w_held_nx;
        end
    end

    // key_code and key_held are loaded on the completing tick so they line up with key_valid.
    always_comb begin
        w_state_nx    = r_state;
        w_col_nx      = r_col;
        w_row_snap_nx = r_row_snap;
        w_deb_cnt_nx  = r_deb_cnt;
        w_code_nx     = r_code;
        w_held_nx     = r_held;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nx = ST_SCAN;
                    w_col_nx   = COL_1;
                end
            end
            ST_SCAN: begin
                if (w_tick) begin
                    if (w_row_idle) begin
                        w_col_nx = next_col(r_col);
                    end else begin
                        w_row_snap_nx = key_row;
                        w_deb_cnt_nx  = '0;
                        w_state_nx    = ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (w_tick) begin
                    if ((key_row == r_row_snap) && w_snap_onehot) begin
                        w_deb_cnt_nx = w_deb_inc;
                        if (r_deb_cnt == DEB_LAST) begin
                            w_state_nx = ST_ACCEPT;
                            w_code_nx  = key_decode(r_col, r_row_snap);
                            w_held_nx  = 1'b1;
                        end
                    end else begin
                        w_state_nx   = ST_SCAN;
                        w_col_nx     = next_col(r_col);
                        w_deb_cnt_nx = '0;
                    end
                end
            end
            ST_ACCEPT: begin
                w_state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_tick && w_row_idle) begin
                    w_deb_cnt_nx = '0;
                    w_state_nx   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_tick) begin
                    if (!w_row_idle) begin
                        w_state_nx = ST_HOLD;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        w_held_nx    = 1'b0;
                        w_col_nx     = next_col(r_col);
                        w_deb_cnt_nx = '0;
                        w_state_nx   = ST_SCAN;
                    end else begin
                        w_deb_cnt_nx = w_deb_inc;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_col_nx   = COL_NONE;
            end
        endcase
    end

    assign key_col   = r_col;
    assign key_valid = (r_state == ST_ACCEPT);
    assign key_code  = r_code;
    assign key_held  = r_held;

endmodule
